// File: rtl/scale_arb_mux.sv
// scale_arb_mux: CHANNELS x SIZE-bit stream mux with round-robin or forced
// select, valid/ready on every port, and a one-beat registered output.
//
// Ports:
//   CLK, RST          rising-edge clock, synchronous active-high reset
//   IN_DATA           channel k in bits [k*SIZE +: SIZE]
//   IN_VALID/IN_READY per-channel handshake (IN_READY is combinational)
//   MODE, SEL         0 = round-robin, 1 = forced channel SEL
//   OUT_DATA/OUT_CH   registered beat and its source channel
//   OUT_VALID/READY   output handshake
module scale_arb_mux #(
   parameter int SIZE     = 8,
   parameter int CHANNELS = 4,
   parameter int SEL_W    = 2
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic [CHANNELS*SIZE-1:0] IN_DATA,
   input  logic [CHANNELS-1:0]      IN_VALID,
   output logic [CHANNELS-1:0]      IN_READY,
   input  logic                     MODE,
   input  logic [SEL_W-1:0]         SEL,
   output logic [SIZE-1:0]          OUT_DATA,
   output logic                     OUT_VALID,
   input  logic                     OUT_READY,
   output logic [SEL_W-1:0]         OUT_CH
);

   logic [SEL_W-1:0] last;
   logic [SEL_W-1:0] grant;
   logic             grant_vld;
   logic             load;
   logic             xfer;
   logic [SIZE-1:0]  grant_data;
   int               idx;

   // Round-robin searches upward from the channel after the last winner.
   // Forced mode only grants an in-range SEL; out-of-range SEL grants nothing.
   always_comb begin
      grant_vld = 1'b0;
      grant     = '0;
      idx       = 0;
      if (!MODE) begin
         for (int i = 1; i <= CHANNELS; i++) begin
            idx = (int'(last) + i) % CHANNELS;
            if (!grant_vld && IN_VALID[idx]) begin
               grant_vld = 1'b1;
               grant     = SEL_W'(idx);
            end
         end
      end else begin
         for (int k = 0; k < CHANNELS; k++) begin
            if (SEL == SEL_W'(k) && IN_VALID[k]) begin
               grant_vld = 1'b1;
               grant     = SEL;
            end
         end
      end
   end

   // The output slot can take a beat when empty or draining this cycle.
   assign load = !OUT_VALID || OUT_READY;
   assign xfer = grant_vld && load && !RST;

   always_comb begin
      IN_READY   = '0;
      grant_data = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         IN_READY[k] = xfer && (grant == SEL_W'(k));
         if (grant == SEL_W'(k))
            grant_data = IN_DATA[k*SIZE +: SIZE];
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         OUT_VALID <= 1'b0;
         OUT_DATA  <= '0;
         OUT_CH    <= '0;
         last      <= SEL_W'(CHANNELS - 1);
      end else if (xfer) begin
         OUT_VALID <= 1'b1;
         OUT_DATA  <= grant_data;
         OUT_CH    <= grant;
         last      <= grant;
      end else if (OUT_READY) begin
         OUT_VALID <= 1'b0;
      end
   end

endmodule

// File: tb/tb_scale_arb_mux.sv
// tb_scale_arb_mux: table-driven vectors plus hand sequences, with a beat
// scoreboard filled from the expected grants and drained on output handshakes.
module tb_scale_arb_mux;

   logic        clk;
   logic        rst;
   logic [31:0] in_data;
   logic [3:0]  in_valid;
   logic [3:0]  in_ready;
   logic        mode;
   logic [1:0]  sel;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic [1:0]  out_ch;

   logic [23:0] in_data3;
   logic [2:0]  in_valid3;
   logic [2:0]  in_ready3;
   logic        mode3;
   logic [1:0]  sel3;
   logic [7:0]  out_data3;
   logic        out_valid3;
   logic        out_ready3;
   logic [1:0]  out_ch3;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [7:0] d;
      logic [1:0] ch;
   } beat_t;
   beat_t sb[$];

   typedef struct {
      logic        r;
      logic        m;
      logic [1:0]  s;
      logic [3:0]  v;
      logic [31:0] d;
      logic        o;
      logic [3:0]  er;
   } vec_t;

   vec_t tbl[19];

   localparam logic [31:0] DA = 32'hA3A2A1A0;
   localparam logic [31:0] DB = 32'h44332211;

   scale_arb_mux #(.SIZE(8), .CHANNELS(4), .SEL_W(2)) dut (
      .CLK(clk), .RST(rst), .IN_DATA(in_data), .IN_VALID(in_valid),
      .IN_READY(in_ready), .MODE(mode), .SEL(sel), .OUT_DATA(out_data),
      .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT_CH(out_ch)
   );

   scale_arb_mux #(.SIZE(8), .CHANNELS(3), .SEL_W(2)) dut3 (
      .CLK(clk), .RST(rst), .IN_DATA(in_data3), .IN_VALID(in_valid3),
      .IN_READY(in_ready3), .MODE(mode3), .SEL(sel3), .OUT_DATA(out_data3),
      .OUT_VALID(out_valid3), .OUT_READY(out_ready3), .OUT_CH(out_ch3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic r, input logic m,
                               input logic [1:0] s, input logic [3:0] v,
                               input logic [31:0] d, input logic o,
                               input logic [3:0] er);
      vec_t t;
      t.r = r; t.m = m; t.s = s; t.v = v; t.d = d; t.o = o; t.er = er;
      return t;
   endfunction

   // One clock: drive, check IN_READY and the outgoing beat, record the
   // expected incoming beat, then step past the edge.
   task automatic step(input vec_t t);
      beat_t b;
      @(negedge clk);
      rst = t.r; mode = t.m; sel = t.s;
      in_valid = t.v; in_data = t.d; out_ready = t.o;
      #2;
      chk("in_ready", 32'(in_ready), 32'(t.er));
      if (!t.r) begin
         chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
         if (out_valid && t.o) begin
            if (sb.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL sb_empty: got beat %h want none", out_data);
            end else begin
               b = sb.pop_front();
               chk("out_data", 32'(out_data), 32'(b.d));
               chk("out_ch", 32'(out_ch), 32'(b.ch));
            end
         end
         for (int k = 0; k < 4; k++) begin
            if (t.er[k] && t.v[k]) begin
               b.d  = t.d[k*8 +: 8];
               b.ch = 2'(k);
               sb.push_back(b);
            end
         end
      end
      @(posedge clk);
      #1;
      if (t.r) sb.delete();
   endtask

   initial begin
      rst = 1'b1; mode = 1'b0; sel = 2'd0; in_valid = 4'h0;
      in_data = DA; out_ready = 1'b0;
      in_data3 = 24'h030201; in_valid3 = 3'b000; mode3 = 1'b0;
      sel3 = 2'd0; out_ready3 = 1'b1;

      // Reset then idle
      step(mk(1, 0, 0, 4'h0, DA, 0, 4'h0));
      step(mk(1, 0, 0, 4'hF, DA, 1, 4'h0));
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_out_ch", 32'(out_ch), 32'd0);

      // Round-robin full load, fixed select, mode-switch fairness
      tbl[0]  = mk(0, 0, 0, 4'hF, DA, 1, 4'b0001);
      tbl[1]  = mk(0, 0, 0, 4'hF, DA, 1, 4'b0010);
      tbl[2]  = mk(0, 0, 0, 4'hF, DA, 1, 4'b0100);
      tbl[3]  = mk(0, 0, 0, 4'hF, DA, 1, 4'b1000);
      tbl[4]  = mk(0, 0, 0, 4'hF, DA, 1, 4'b0001);
      tbl[5]  = mk(0, 0, 0, 4'hF, DA, 1, 4'b0010);
      tbl[6]  = mk(0, 0, 0, 4'hF, DA, 1, 4'b0100);
      tbl[7]  = mk(0, 0, 0, 4'hF, DA, 1, 4'b1000);
      tbl[8]  = mk(0, 1, 1, 4'b1011, DA, 1, 4'b0010);
      tbl[9]  = mk(0, 1, 1, 4'b1011, DA, 1, 4'b0010);
      tbl[10] = mk(0, 1, 2, 4'b1011, DA, 1, 4'b0000);
      tbl[11] = mk(0, 1, 2, 4'b1011, DA, 1, 4'b0000);
      tbl[12] = mk(0, 1, 2, 4'hF, DA, 1, 4'b0100);
      tbl[13] = mk(0, 0, 0, 4'hF, DA, 1, 4'b1000);
      tbl[14] = mk(0, 0, 0, 4'h0, DA, 1, 4'b0000);
      tbl[15] = mk(0, 0, 0, 4'b0110, DB, 1, 4'b0010);
      tbl[16] = mk(0, 0, 0, 4'b0110, DB, 1, 4'b0100);
      tbl[17] = mk(0, 0, 0, 4'h0, DB, 0, 4'b0000);
      tbl[18] = mk(0, 0, 0, 4'h0, DB, 1, 4'b0000);
      for (int i = 0; i < 19; i++) step(tbl[i]);

      // Backpressure: ch2 beat 55 held while downstream stalls
      step(mk(0, 1, 2, 4'b0100, 32'h66552211, 1, 4'b0100));
      for (int i = 0; i < 3; i++) begin
         step(mk(0, 0, 0, 4'hF, 32'h66552211, 0, 4'b0000));
         chk("bp_hold_data", 32'(out_data), 32'h55);
         chk("bp_hold_ch", 32'(out_ch), 32'd2);
         chk("bp_hold_valid", 32'(out_valid), 32'd1);
      end
      step(mk(0, 0, 0, 4'hF, 32'h66552211, 1, 4'b1000));
      chk("bp_next_data", 32'(out_data), 32'h66);
      chk("bp_next_ch", 32'(out_ch), 32'd3);
      step(mk(0, 0, 0, 4'h0, DA, 1, 4'b0000));

      // Mid-operation reset while holding C3
      step(mk(0, 1, 0, 4'b0001, 32'hA3A2A1C3, 1, 4'b0001));
      step(mk(0, 0, 0, 4'h0, DA, 0, 4'b0000));
      chk("pre_rst_data", 32'(out_data), 32'hC3);
      step(mk(1, 0, 0, 4'hF, DA, 0, 4'b0000));
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_data", 32'(out_data), 32'd0);
      chk("mid_rst_ch", 32'(out_ch), 32'd0);
      step(mk(0, 0, 0, 4'hF, DA, 1, 4'b0001));
      step(mk(0, 0, 0, 4'h0, DA, 1, 4'b0000));

      // Three-channel instance: out-of-range SEL and wrap-around
      @(negedge clk);
      mode3 = 1'b1; sel3 = 2'd3; in_valid3 = 3'b111;
      #2;
      chk("c3_sel3_ready", 32'(in_ready3), 32'b000);
      @(posedge clk); #1;
      chk("c3_sel3_valid", 32'(out_valid3), 32'd0);
      @(negedge clk);
      sel3 = 2'd2;
      #2;
      chk("c3_sel2_ready", 32'(in_ready3), 32'b100);
      @(posedge clk); #1;
      chk("c3_sel2_data", 32'(out_data3), 32'h03);
      chk("c3_sel2_ch", 32'(out_ch3), 32'd2);
      @(negedge clk);
      mode3 = 1'b0;
      #2;
      chk("c3_wrap_ready", 32'(in_ready3), 32'b001);
      @(posedge clk); #1;
      chk("c3_wrap_data", 32'(out_data3), 32'h01);

      if (sb.size() != 0) begin
         n_cmp++; n_err++;
         $display("FAIL sb_leftover: got %0d beats want 0", sb.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
